// File: rtl/ped_request_conditioner_if.sv
// Signal bundle between the pedestrian request conditioner and its controller/button side.
// state_dbg encoding: 0 = IDLE, 1 = PENDING, 2 = SERVING.
interface ped_request_conditioner_if;
    logic       b_npeaton;
    logic       req_ack;
    logic       ped_phase;
    logic       req;
    logic       press_pulse;
    logic       btn_pressed;
    logic       sol_light;
    logic [7:0] req_count;
    logic [1:0] state_dbg;

    // req/req_ack: req is a level held until the controller answers with a one-cycle
    // req_ack; the request is consumed on the clock edge where req && req_ack.
    modport master (
        output b_npeaton, req_ack, ped_phase,
        input  req, press_pulse, btn_pressed, sol_light, req_count, state_dbg
    );

    modport slave (
        input  b_npeaton, req_ack, ped_phase,
        output req, press_pulse, btn_pressed, sol_light, req_count, state_dbg
    );
endinterface

// File: rtl/ped_request_conditioner.sv
// Pedestrian push-button conditioner: sync, debounce, edge detect, request hold until grant.
// Optional macro PED_LED_BLINK_EN makes the request LED blink at 2 Hz while a request is pending.
module ped_request_conditioner #(
    parameter int FPGAFREQ    = 50_000_000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic                        clk,
    input  logic                        reset,
    ped_request_conditioner_if.slave    bus
);
    localparam int DB_CYCLES = FPGAFREQ / 1000 * DEBOUNCE_MS;
    localparam int CW        = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVING = 2'd2
    } state_t;

    state_t        state;
    logic          sync1, sync2;
    logic          btn_q, btn_d, pulse_q;
    logic [CW-1:0] db_cnt;
    logic          ped_d;
    logic          req_q;
    logic [7:0]    cnt_q;

    // Button path: the raw pin is inverted so all internal levels read 1 = pressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            btn_q   <= 1'b0;
            btn_d   <= 1'b0;
            pulse_q <= 1'b0;
            db_cnt  <= '0;
        end else begin
            sync1   <= ~bus.b_npeaton;
            sync2   <= sync1;
            btn_d   <= btn_q;
            pulse_q <= btn_q & ~btn_d;
            if (sync2 == btn_q) begin
                db_cnt <= '0;
            end else if (db_cnt == CW'(DB_CYCLES - 1)) begin
                btn_q  <= ~btn_q;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CW'(1);
            end
        end
    end

    // Request FSM; req is registered alongside the state so it always equals (state == PENDING).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            req_q <= 1'b0;
            cnt_q <= 8'd0;
            ped_d <= 1'b0;
        end else begin
            ped_d <= bus.ped_phase;
            case (state)
                IDLE: begin
                    if (pulse_q && !bus.ped_phase) begin
                        state <= PENDING;
                        req_q <= 1'b1;
                        if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
                    end
                end
                PENDING: begin
                    if (bus.req_ack) begin
                        state <= SERVING;
                        req_q <= 1'b0;
                    end
                end
                SERVING: begin
                    if (ped_d && !bus.ped_phase) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PED_LED_BLINK_EN
    localparam int BLINK_HALF = (FPGAFREQ / 4 >= 1) ? FPGAFREQ / 4 : 1;
    localparam int BW         = $clog2(BLINK_HALF + 1);

    logic          enter_pending;
    logic          stay_pending;
    logic          sol_q;
    logic [BW-1:0] blink_cnt;

    assign enter_pending = (state == IDLE) && pulse_q && !bus.ped_phase;
    assign stay_pending  = (state == PENDING) && !bus.req_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sol_q     <= 1'b0;
            blink_cnt <= '0;
        end else if (enter_pending) begin
            sol_q     <= 1'b1;
            blink_cnt <= '0;
        end else if (stay_pending) begin
            if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                sol_q     <= ~sol_q;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end else begin
            sol_q     <= 1'b0;
            blink_cnt <= '0;
        end
    end

    assign bus.sol_light = sol_q;
`else
    assign bus.sol_light = req_q;
`endif

    assign bus.req         = req_q;
    assign bus.press_pulse = pulse_q;
    assign bus.btn_pressed = btn_q;
    assign bus.req_count   = cnt_q;
    assign bus.state_dbg   = state;
endmodule
